cla_serial_addsub: RTL and testbench

- Multi-cycle N-nibble adder/subtractor. Processes one 4-bit nibble per clock, LSB nibble first.
- Each nibble is computed with 4-bit carry-lookahead equations (g = a&b, p = a|b, c1..c4 in lookahead form). The nibble carry-out is registered and chained to the next nibble.
- Subtraction is the inverse path of the lookahead adder: b is inverted and the carry-in is adjusted.
- Used as a small sequential benchmark around the lookahead carry logic, with a start/done handshake.

---
 rtl/cla_serial_addsub.sv | 104 ++++++++++
 tb/tb_cla_serial_addsub.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_addsub.sv
// Nibble-serial adder/subtractor built around 4-bit carry-lookahead slices.
// One nibble per clock, LSB first, with a start/done handshake.
module cla_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [KW-1:0] k;
  logic [W-1:0]  a_q, b_q;
  logic          carry;
  logic          ready, accept, last;

  logic [3:0] na, nb, g, p, ns;
  logic [4:0] c;

  assign ready  = (state == IDLE) || (state == DONE);
  assign accept = start && ready;
  assign last   = (k == KW'(NIBBLES - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last)   state_nx = DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lookahead slice on the current nibble
  always_comb begin
    na   = a_q[4*k +: 4];
    nb   = b_q[4*k +: 4];
    g    = na & nb;
    p    = na | nb;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    ns   = na ^ nb ^ c[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= cin ^ sub;
      k     <= '0;
      sum   <= '0;
    end else if (state == RUN) begin
      sum[4*k +: 4] <= ns;
      carry         <= c[4];
      if (last) begin
        cout <= c[4];
        ovf  <= c[3] ^ c[4];
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cla_serial_addsub.sv
// Randomized and directed checks of cla_serial_addsub
// against a plain-arithmetic reference model.
module tb_cla_serial_addsub;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  logic [W-1:0] exp_sum;
  logic         exp_cout, exp_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_serial_addsub #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference: integer arithmetic, unsigned for carry, signed for overflow
  function automatic void model(input logic s, input logic c,
                                input logic [W-1:0] x,
                                input logic [W-1:0] y,
                                output logic [W-1:0] r,
                                output logic co, output logic ov);
    longint ux, uy, sx, sy, t, st;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      t  = ux + uy + longint'(c);
      st = sx + sy + longint'(c);
      co = (t >= (longint'(1) << W));
    end else begin
      t  = ux - uy - longint'(c);
      st = sx - sy - longint'(c);
      co = (t >= 0);
    end
    r  = t[W-1:0];
    ov = (st > (longint'(1) << (W-1)) - 1) ||
         (st < -(longint'(1) << (W-1)));
  endfunction

  task automatic issue(input logic s, input logic c,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    sub   = s;
    cin   = c;
    a     = x;
    b     = y;
    start = 1'b1;
    model(s, c, x, y, exp_sum, exp_cout, exp_ovf);
  endtask

  task automatic await_done(input string tag, input bit poke);
    int cyc;
    cyc = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
    cin   = 1'($urandom);
    @(negedge clk);
    while (!done && cyc < 20) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (poke && cyc == 1) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'(NIB));
    chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic         s;
    logic         c;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } vec_t;

  vec_t dir[6];
  bit   seen;

  initial begin
    dir[0] = '{1'b0, 1'b0, 16'h1234, 16'h4321};
    dir[1] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000};
    dir[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001};
    dir[3] = '{1'b1, 1'b0, 16'h8000, 16'h0001};
    dir[4] = '{1'b1, 1'b0, 16'h0000, 16'h0001};
    dir[5] = '{1'b1, 1'b1, 16'h0005, 16'h0003};

    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (dir[i]) begin
      issue(dir[i].s, dir[i].c, dir[i].x, dir[i].y);
      await_done($sformatf("dir%0d", i), 1'b0);
      @(negedge clk);
      chk($sformatf("dir%0d_pulse", i), 32'(done), 32'd0);
    end

    issue(1'b0, 1'b0, 16'h1111, 16'h2222);
    await_done("ignore", 1'b1);
    @(negedge clk);

    issue(1'b0, 1'b0, 16'h00FF, 16'h0001);
    await_done("b2b1", 1'b0);
    issue(1'b1, 1'b0, 16'h1000, 16'h0001);
    await_done("b2b2", 1'b0);
    @(negedge clk);
    chk("b2b_pulse", 32'(done), 32'd0);

    issue(1'b0, 1'b0, 16'hABCD, 16'h1111);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      seen |= done;
    end
    chk("arst_nodone", 32'(seen), 32'd0);
    issue(1'b1, 1'b0, 16'h4000, 16'h0FFF);
    await_done("post_rst", 1'b0);
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      issue(1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
      await_done($sformatf("rnd%0d", i), 1'($urandom));
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(2, 1)) @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
